// File: rtl/ofdm_tx_pkg.sv
// Shared constants, state encoding and Q1.15 training-sequence tables for the
// OFDM preamble transmitter.
package ofdm_tx_pkg;

  localparam int SAMPLE_W = 16;
  localparam int STS_LEN  = 160;
  localparam int LTS_LEN  = 160;
  localparam int LTS_CP   = 32;
  localparam int FFT_N    = 64;
  localparam int STS_PER  = 16;
  localparam int CNT_W    = 9;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_STS     = 2'd1,
    S_LTS     = 2'd2,
    S_PAYLOAD = 2'd3
  } tx_state_t;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  // One period of the normalized short training sequence, x32768 and rounded.
  localparam sample_t STS_I [0:STS_PER-1] = '{
     16'sd1507, -16'sd4325,  -16'sd426,  16'sd4686,  16'sd3015,  16'sd4686,  -16'sd426, -16'sd4325,
     16'sd1507,    16'sd66, -16'sd2589,  -16'sd426,     16'sd0,  -16'sd426, -16'sd2589,    16'sd66
  };
  localparam sample_t STS_Q [0:STS_PER-1] = '{
     16'sd1507,    16'sd66, -16'sd2589,  -16'sd426,     16'sd0,  -16'sd426, -16'sd2589,    16'sd66,
     16'sd1507, -16'sd4325,  -16'sd426,  16'sd4686,  16'sd3015,  16'sd4686,  -16'sd426, -16'sd4325
  };

  // One 64-sample long training symbol, x32768 and rounded.
  localparam sample_t LTS_I [0:FFT_N-1] = '{
     16'sd5112,  -16'sd164,  16'sd1311,  16'sd3178,   16'sd688,  16'sd1966, -16'sd3768, -16'sd1245,
     16'sd3211,  16'sd1737,    16'sd33, -16'sd4489,   16'sd786,  16'sd1933,  -16'sd721,  16'sd3899,
     16'sd2032,  16'sd1212, -16'sd1868, -16'sd4293,  16'sd2687,  16'sd2294, -16'sd1966, -16'sd1835,
    -16'sd1147, -16'sd3998, -16'sd4162,  16'sd2458,   -16'sd98, -16'sd3015,  16'sd3015,   16'sd393,
    -16'sd5112,   16'sd393,  16'sd3015, -16'sd3015,   -16'sd98,  16'sd2458, -16'sd4162, -16'sd3998,
    -16'sd1147, -16'sd1835, -16'sd1966,  16'sd2294,  16'sd2687, -16'sd4293, -16'sd1868,  16'sd1212,
     16'sd2032,  16'sd3899,  -16'sd721,  16'sd1933,   16'sd786, -16'sd4489,    16'sd33,  16'sd1737,
     16'sd3211, -16'sd1245, -16'sd3768,  16'sd1966,   16'sd688,  16'sd3178,  16'sd1311,  -16'sd164
  };
  localparam sample_t LTS_Q [0:FFT_N-1] = '{
        16'sd0, -16'sd3932, -16'sd3637,  16'sd2720,   16'sd918, -16'sd2884, -16'sd1802, -16'sd3473,
     -16'sd852,   16'sd131, -16'sd3768, -16'sd1540, -16'sd1933,  -16'sd492,  16'sd5276,  -16'sd131,
    -16'sd2032,  16'sd3211,  16'sd1278,  16'sd2130,  16'sd3015,   16'sd459,  16'sd2654,  -16'sd721,
    -16'sd4948,  -16'sd557,  -16'sd688, -16'sd2425,  16'sd1769,  16'sd3768,  16'sd3473,  16'sd3211,
        16'sd0, -16'sd3211, -16'sd3473, -16'sd3768, -16'sd1769,  16'sd2425,   16'sd688,   16'sd557,
     16'sd4948,   16'sd721, -16'sd2654,  -16'sd459, -16'sd3015, -16'sd2130, -16'sd1278, -16'sd3211,
     16'sd2032,   16'sd131, -16'sd5276,   16'sd492,  16'sd1933,  16'sd1540,  16'sd3768,  -16'sd131,
      16'sd852,  16'sd3473,  16'sd1802,  16'sd2884,  -16'sd918, -16'sd2720,  16'sd3637,  16'sd3932
  };

endpackage

// File: rtl/preamble_rom.sv
// Combinational training-sequence lookup: LTS always, STS only when built with
// OFDM_TX_STS_EN.
module preamble_rom
  import ofdm_tx_pkg::*;
(
  input  logic [5:0] i_lts_idx,
  output sample_t    o_lts_i,
  output sample_t    o_lts_q
`ifdef OFDM_TX_STS_EN
  ,
  input  logic [3:0] i_sts_idx,
  output sample_t    o_sts_i,
  output sample_t    o_sts_q
`endif
);

  assign o_lts_i = LTS_I[i_lts_idx];
  assign o_lts_q = LTS_Q[i_lts_idx];

`ifdef OFDM_TX_STS_EN
  assign o_sts_i = STS_I[i_sts_idx];
  assign o_sts_q = STS_Q[i_sts_idx];
`endif

endmodule

// File: rtl/ofdm_preamble_tx.sv
// OFDM frame transmitter: STS (when OFDM_TX_STS_EN is defined), LTS with CP,
// then a fixed-length payload forwarded from upstream, one sample per tick.
module ofdm_preamble_tx
  import ofdm_tx_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int LEN_W    = 16
) (
  input  logic                       CLK,
  input  logic                       s_RST,
  input  logic                       sample_tick,
  input  logic                       tx_start,
  input  logic [LEN_W-1:0]           payload_len,
  input  logic signed [SAMPLE_W-1:0] payload_I,
  input  logic signed [SAMPLE_W-1:0] payload_Q,
  input  logic                       payload_valid,
  output logic                       payload_ready,
  output logic signed [SAMPLE_W-1:0] I_out,
  output logic signed [SAMPLE_W-1:0] Q_out,
  output logic                       output_strobe,
  output logic                       busy,
  output logic                       in_preamble,
  output logic                       done,
  output logic                       underrun
);

  tx_state_t                 r_state, w_state_nxt;
  logic [CNT_W-1:0]          r_cnt, w_cnt_nxt;
  logic [LEN_W-1:0]          r_remain, w_remain_nxt;
  logic signed [SAMPLE_W-1:0] r_i_p1, w_i_p0;
  logic signed [SAMPLE_W-1:0] r_q_p1, w_q_p0;
  logic                      r_vld_p1, w_vld_p0;
  logic                      r_pre_p1, w_pre_p0;
  logic                      r_done, w_done_nxt;
  logic                      r_underrun, w_underrun_nxt;

  logic [5:0]                w_lts_idx;
  sample_t                   w_lts_i, w_lts_q;

  // CP is the second half of the symbol, so the walk starts at sample 32.
  assign w_lts_idx = r_cnt[5:0] + 6'(LTS_CP);

`ifdef OFDM_TX_STS_EN
  sample_t                   w_sts_i, w_sts_q;

  preamble_rom u_rom (
    .i_lts_idx (w_lts_idx),
    .o_lts_i   (w_lts_i),
    .o_lts_q   (w_lts_q),
    .i_sts_idx (r_cnt[3:0]),
    .o_sts_i   (w_sts_i),
    .o_sts_q   (w_sts_q)
  );
`else
  preamble_rom u_rom (
    .i_lts_idx (w_lts_idx),
    .o_lts_i   (w_lts_i),
    .o_lts_q   (w_lts_q)
  );
`endif

  assign payload_ready = sample_tick & payload_valid & (r_state == S_PAYLOAD);

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_remain_nxt   = r_remain;
    w_i_p0         = r_i_p1;
    w_q_p0         = r_q_p1;
    w_vld_p0       = 1'b0;
    w_pre_p0       = 1'b0;
    w_done_nxt     = 1'b0;
    w_underrun_nxt = r_underrun;
    case (r_state)
      S_IDLE: begin
        w_i_p0 = '0;
        w_q_p0 = '0;
        if (tx_start) begin
          w_remain_nxt   = payload_len;
          w_underrun_nxt = 1'b0;
          w_cnt_nxt      = '0;
`ifdef OFDM_TX_STS_EN
          w_state_nxt    = S_STS;
`else
          w_state_nxt    = S_LTS;
`endif
        end
      end
`ifdef OFDM_TX_STS_EN
      S_STS: begin
        if (sample_tick) begin
          w_i_p0   = w_sts_i;
          w_q_p0   = w_sts_q;
          w_vld_p0 = 1'b1;
          w_pre_p0 = 1'b1;
          if (r_cnt == CNT_W'(STS_LEN - 1)) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_LTS;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
`endif
      S_LTS: begin
        if (sample_tick) begin
          w_i_p0   = w_lts_i;
          w_q_p0   = w_lts_q;
          w_vld_p0 = 1'b1;
          w_pre_p0 = 1'b1;
          if (r_cnt == CNT_W'(LTS_LEN - 1)) begin
            w_cnt_nxt = '0;
            if (r_remain == '0) begin
              w_done_nxt  = 1'b1;
              w_state_nxt = S_IDLE;
            end else begin
              w_state_nxt = S_PAYLOAD;
            end
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_PAYLOAD: begin
        // A missing upstream sample burns its slot so frame length never moves.
        if (sample_tick) begin
          if (payload_valid) begin
            w_i_p0   = payload_I;
            w_q_p0   = payload_Q;
            w_vld_p0 = 1'b1;
          end else begin
            w_underrun_nxt = 1'b1;
          end
          w_remain_nxt = r_remain - 1'b1;
          if (r_remain == LEN_W'(1)) begin
            w_done_nxt  = 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---- output register stage (p1) ----
  always_ff @(posedge CLK or negedge s_RST) begin
    if (!s_RST) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_remain   <= '0;
      r_i_p1     <= '0;
      r_q_p1     <= '0;
      r_vld_p1   <= 1'b0;
      r_pre_p1   <= 1'b0;
      r_done     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_remain   <= w_remain_nxt;
      r_i_p1     <= w_i_p0;
      r_q_p1     <= w_q_p0;
      r_vld_p1   <= w_vld_p0;
      r_pre_p1   <= w_pre_p0;
      r_done     <= w_done_nxt;
      r_underrun <= w_underrun_nxt;
    end
  end

  assign I_out         = r_i_p1;
  assign Q_out         = r_q_p1;
  assign output_strobe = r_vld_p1;
  assign in_preamble   = r_pre_p1;
  assign done          = r_done;
  assign underrun      = r_underrun;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_ofdm_preamble_tx.sv
// Directed bench for ofdm_preamble_tx; adapts preamble length to OFDM_TX_STS_EN.
module tb_ofdm_preamble_tx;

`ifdef OFDM_TX_STS_EN
  localparam int  PRE_LEN = 320;
  localparam longint FIRST_I = 1507;
  localparam longint FIRST_Q = 1507;
`else
  localparam int  PRE_LEN = 160;
  localparam longint FIRST_I = -5112;
  localparam longint FIRST_Q = 0;
`endif
  localparam int LTS0 = PRE_LEN - 160;

  logic               CLK = 1'b0;
  logic               s_RST = 1'b0;
  logic               sample_tick = 1'b0;
  logic               tx_start = 1'b0;
  logic [15:0]        payload_len = '0;
  logic signed [15:0] payload_I = '0;
  logic signed [15:0] payload_Q = '0;
  logic               payload_valid = 1'b0;
  logic               payload_ready;
  logic signed [15:0] I_out, Q_out;
  logic               output_strobe, busy, in_preamble, done, underrun;

  ofdm_preamble_tx #(.SAMPLE_W(16), .LEN_W(16)) dut (
    .CLK           (CLK),
    .s_RST         (s_RST),
    .sample_tick   (sample_tick),
    .tx_start      (tx_start),
    .payload_len   (payload_len),
    .payload_I     (payload_I),
    .payload_Q     (payload_Q),
    .payload_valid (payload_valid),
    .payload_ready (payload_ready),
    .I_out         (I_out),
    .Q_out         (Q_out),
    .output_strobe (output_strobe),
    .busy          (busy),
    .in_preamble   (in_preamble),
    .done          (done),
    .underrun      (underrun)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;

  logic signed [15:0] cap_i[$];
  logic signed [15:0] cap_q[$];
  int n_done, done_iter, n_ready, n_pre, done_strobes;
  logic done_had_strobe, busy_at_done;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint cap_at(input int idx, input bit q);
    if (idx < 0 || idx >= cap_i.size()) return -99999;
    return q ? longint'(cap_q[idx]) : longint'(cap_i[idx]);
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Start pulse coincides with a tick, which must not be consumed.
  task automatic start_frame(input int plen);
    payload_len = 16'(plen);
    tx_start    = 1'b1;
    sample_tick = 1'b1;
    step();
    tx_start    = 1'b0;
    sample_tick = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("no_strobe_on_start", output_strobe, 0);
  endtask

  // Continuous ticks; payload sample p carries I=100+p, Q=200+p.
  task automatic collect(input int ncyc, input int plen, input int drop_idx, input int inject_at);
    int k;
    int p;
    cap_i.delete();
    cap_q.delete();
    n_done = 0; done_iter = -1; n_ready = 0; n_pre = 0; done_strobes = -1;
    done_had_strobe = 1'b0; busy_at_done = 1'b1;
    k = 0;
    for (int c = 0; c < ncyc; c++) begin
      p             = k - PRE_LEN;
      sample_tick   = 1'b1;
      payload_I     = 16'(100 + p);
      payload_Q     = 16'(200 + p);
      payload_valid = (p != drop_idx);
      tx_start      = (c == inject_at);
      payload_len   = (c == inject_at) ? 16'd9 : 16'(plen);
      #1;
      if (payload_ready) n_ready++;
      @(posedge CLK);
      #1;
      k++;
      tx_start = 1'b0;
      if (output_strobe) begin
        cap_i.push_back(I_out);
        cap_q.push_back(Q_out);
        if (in_preamble) n_pre++;
      end
      if (done) begin
        n_done++;
        done_iter       = k;
        done_had_strobe = output_strobe;
        busy_at_done    = busy;
        done_strobes    = cap_i.size();
      end
    end
    sample_tick   = 1'b0;
    payload_valid = 1'b0;
  endtask

  initial begin
    int nd;

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_I", I_out, 0);
    chk("rst_Q", Q_out, 0);
    chk("rst_strobe", output_strobe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pre", in_preamble, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    s_RST = 1'b1;
    step();
    sample_tick = 1'b1; payload_valid = 1'b1;
    #1;
    chk("idle_ready", payload_ready, 0);
    step();
    chk("idle_tick_no_strobe", output_strobe, 0);
    chk("idle_I_zero", I_out, 0);
    sample_tick = 1'b0; payload_valid = 1'b0;
    step();

    // Frame with no payload
    start_frame(0);
    collect(PRE_LEN + 4, 0, -1, -1);
    chk("f0_strobes", cap_i.size(), PRE_LEN);
    chk("f0_first_I", cap_at(0, 0), FIRST_I);
    chk("f0_first_Q", cap_at(0, 1), FIRST_Q);
`ifdef OFDM_TX_STS_EN
    chk("f0_sts1_I", cap_at(1, 0), -4325);
    chk("f0_sts1_Q", cap_at(1, 1), 66);
    chk("f0_sts16_I", cap_at(16, 0), 1507);
    chk("f0_sts159_Q", cap_at(159, 1), -4325);
`endif
    chk("f0_cp0_I", cap_at(LTS0, 0), -5112);
    chk("f0_cp0_Q", cap_at(LTS0, 1), 0);
    chk("f0_cp1_I", cap_at(LTS0 + 1, 0), 393);
    chk("f0_cp1_Q", cap_at(LTS0 + 1, 1), -3211);
    chk("f0_sym1_I", cap_at(LTS0 + 32, 0), 5112);
    chk("f0_sym1_Q", cap_at(LTS0 + 32, 1), 0);
    chk("f0_sym2_I", cap_at(LTS0 + 96, 0), 5112);
    chk("f0_last_I", cap_at(PRE_LEN - 1, 0), -164);
    chk("f0_last_Q", cap_at(PRE_LEN - 1, 1), 3932);
    chk("f0_pre_cnt", n_pre, PRE_LEN);
    chk("f0_done_cnt", n_done, 1);
    chk("f0_done_iter", done_iter, PRE_LEN);
    chk("f0_done_on_last", done_strobes, PRE_LEN);
    chk("f0_done_strobe", done_had_strobe, 1);
    chk("f0_busy_at_done", busy_at_done, 0);

    // Four valid payload samples
    start_frame(4);
    collect(PRE_LEN + 8, 4, -1, -1);
    chk("f4_strobes", cap_i.size(), PRE_LEN + 4);
    chk("f4_p0_I", cap_at(PRE_LEN, 0), 100);
    chk("f4_p1_I", cap_at(PRE_LEN + 1, 0), 101);
    chk("f4_p2_Q", cap_at(PRE_LEN + 2, 1), 202);
    chk("f4_p3_I", cap_at(PRE_LEN + 3, 0), 103);
    chk("f4_ready_cnt", n_ready, 4);
    chk("f4_pre_cnt", n_pre, PRE_LEN);
    chk("f4_underrun", underrun, 0);
    chk("f4_done_iter", done_iter, PRE_LEN + 4);
    chk("f4_done_cnt", n_done, 1);

    // Underrun on second payload tick
    start_frame(3);
    collect(PRE_LEN + 6, 3, 1, -1);
    chk("fu_strobes", cap_i.size(), PRE_LEN + 2);
    chk("fu_p0_I", cap_at(PRE_LEN, 0), 100);
    chk("fu_p1_I", cap_at(PRE_LEN + 1, 0), 102);
    chk("fu_ready_cnt", n_ready, 2);
    chk("fu_underrun", underrun, 1);
    chk("fu_done_iter", done_iter, PRE_LEN + 3);
    chk("fu_done_cnt", n_done, 1);

    // Next start clears underrun; a start during LTS is ignored
    start_frame(0);
    chk("clr_underrun", underrun, 0);
    collect(PRE_LEN + 6, 0, -1, PRE_LEN - 100);
    chk("ign_strobes", cap_i.size(), PRE_LEN);
    chk("ign_done_cnt", n_done, 1);
    chk("ign_done_iter", done_iter, PRE_LEN);

    // Reset in the middle of LTS
    start_frame(2);
    collect(PRE_LEN - 80, 2, -1, -1);
    chk("mid_busy", busy, 1);
    chk("mid_strobe", output_strobe, 1);
    #2;
    s_RST = 1'b0;
    #1;
    chk("mr_I", I_out, 0);
    chk("mr_Q", Q_out, 0);
    chk("mr_strobe", output_strobe, 0);
    chk("mr_busy", busy, 0);
    chk("mr_pre", in_preamble, 0);
    nd = 0;
    sample_tick = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done) nd++;
    end
    s_RST = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      if (done) nd++;
    end
    sample_tick = 1'b0;
    chk("mr_no_done", nd, 0);
    start_frame(0);
    collect(PRE_LEN + 4, 0, -1, -1);
    chk("rs_first_I", cap_at(0, 0), FIRST_I);
    chk("rs_first_Q", cap_at(0, 1), FIRST_Q);
    chk("rs_strobes", cap_i.size(), PRE_LEN);
    chk("rs_done_cnt", n_done, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ofdm_preamble_tx.md
# ofdm_preamble_tx

Transmit-side framing block for the OFDM link: on a start pulse it emits the 802.11a-style short training sequence (STS), then the long training sequence (LTS, 32-sample CP plus two 64-sample symbols), then forwards a fixed number of payload samples from an upstream source. Output is one 16-bit signed I/Q sample per sample tick, in the same format the receiver's short/long synchronizers consume. It sits between the transmit IFFT/CP stage (payload source) and the DAC or loopback path feeding the receiver bench.

## Interface
- SAMPLE_W, 16, I/Q sample width (signed, Q1.15)
- LEN_W, 16, width of payload length
- CLK  in  1  system clock
- s_RST  in  1  asynchronous, active-low reset
- sample_tick  in  1  one-cycle pulse per output sample period (the transmit sample strobe)
- tx_start  in  1  one-cycle pulse, starts a frame; honoured only in IDLE
- payload_len  in  LEN_W  payload samples to forward; captured on accepted tx_start
- payload_I, payload_Q  in  SAMPLE_W each  upstream payload sample
- payload_valid  in  1  upstream sample available
- payload_ready  out  1  upstream sample consumed this cycle
- I_out, Q_out  out  SAMPLE_W each  output sample, registered
- output_strobe  out  1  I_out/Q_out valid, one cycle
- busy  out  1  frame in progress
- in_preamble  out  1  current output sample is STS or LTS
- done  out  1  one-cycle pulse after last payload sample
- underrun  out  1  sticky: payload_valid low on a payload tick; cleared by accepted tx_start

## Operation
- States: IDLE, STS, LTS, PAYLOAD. Single sample counter cnt (9 bits) plus payload counter (LEN_W).
- IDLE: tx_start -> capture payload_len, clear underrun, cnt=0, go STS (or LTS if STS compiled out); busy=1 from next cycle.
- STS: on each tick output sts_rom[cnt mod 16]; after 160 ticks (cnt=159) go LTS, cnt=0.
- LTS: on each tick output lts_rom[(cnt+32) mod 64] for cnt 0..159 (CP = LTS samples 32..63, then two full symbols); after cnt=159 go PAYLOAD, or IDLE with done if payload_len=0.
- PAYLOAD: payload_ready = sample_tick & payload_valid & state==PAYLOAD (combinational). On tick with valid: output payload sample, decrement remaining. On tick without valid: no output_strobe, set underrun, sample slot lost (no retry), remaining still decremented so frame length is fixed. At remaining reaching 0: done pulse, go IDLE.
- ROM constants: STS s[0] = (1507, 1507) (0.046+0.046j), LTS t[0] = (5112, 0) (0.156). All ROM values Q1.15 rounded-to-nearest of the standard normalized time-domain sequences.
- tx_start while busy: ignored, no effect on any state.
- Ticks in IDLE: no output_strobe, outputs hold zero.

## Timing
- Reset (async assert, sync-released): state IDLE, I_out=Q_out=0, output_strobe=0, busy=0, in_preamble=0, done=0, underrun=0, counters 0.
- Latency: sample produced on tick in cycle t appears with output_strobe in cycle t+1; in_preamble aligned with output_strobe.
- tick in same cycle as accepted tx_start: not consumed; first STS sample goes out on the next tick.
- done asserted in cycle after final payload tick (same cycle as last output_strobe); busy falls same cycle.
- Reset mid-frame: all outputs to reset values immediately; no done pulse.
- Frame length exactly 320 + payload_len ticks (160 + payload_len without STS).

## Configuration
- OFDM_TX_STS_EN defined: STS state and 16-entry STS ROM present; frame = STS, LTS, payload.
- Not defined: STS state and ROM removed; IDLE goes directly to LTS; in_preamble covers LTS only.

## Structure
- Package ofdm_tx_pkg: SAMPLE_W, STS_LEN=160, LTS_LEN=160, LTS_CP=32, FFT_N=64, state encoding, ROM contents as constants.
- Sub-module preamble_rom: combinational 64-entry LTS and (under OFDM_TX_STS_EN) 16-entry STS lookup, index in, I/Q out.

## Test plan
- Reset then tx_start, payload_len=0, continuous ticks -> 320 strobes, first (1507,1507), sample 160 = LTS[32], sample 192 = (5112,0), done on 320th strobe, busy low after.
- payload_len=4, payload_valid=1 with samples 100..103 -> strobes 321..324 carry 100..103, payload_ready exactly 4 cycles, underrun=0.
- payload_len=3, payload_valid low on 2nd payload tick -> only 2 payload strobes, underrun=1, done still after 3rd payload tick; next tx_start clears underrun.
- tx_start pulsed during LTS -> ignored, frame length unchanged, single done.
- s_RST asserted mid-LTS -> outputs zero same cycle, no done; new tx_start restarts at STS sample 0.
- Build without OFDM_TX_STS_EN, payload_len=0 -> 160 strobes, first (LTS[32]), done on 160th.
